// File: rtl/siso_maxlog_stream.sv
// Streaming max-log-MAP SISO for the 4-state RSC constituent code.
// Symbols are taken one per handshake while the forward (alpha) recursion
// runs. A backward pass then computes beta and one LLR per cycle into a
// buffer, and the buffer is streamed out through a valid/ready port.
module siso_maxlog_stream #(
    parameter int DATA_W  = 10,
    parameter int IN_W    = 4,
    parameter int K       = 7,
    parameter int NORM_EN = 1
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [IN_W-1:0]   sys_i,
    input  logic [IN_W-1:0]   enc_i,
    input  logic [DATA_W-1:0] ext_i,
    input  logic              mode_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] llr_o,
    output logic              out_last_o,
    output logic              done_o
);

    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_BWD  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    // Four state metrics, element [s] belongs to trellis state s.
    typedef logic [3:0][DATA_W-1:0] metric4_t;

    localparam logic [DATA_W-1:0] NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam metric4_t INIT_METRIC = {NEG, NEG, NEG, {DATA_W{1'b0}}};

    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1]) return s[DATA_W] ? NEG : POS;
        return s[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1]) return s[DATA_W] ? NEG : POS;
        return s[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] sext(input logic [IN_W-1:0] x);
        return {{(DATA_W-IN_W){x[IN_W-1]}}, x};
    endfunction

    // Systematic-plus-a-priori term shared by all branches of a step.
    function automatic logic [DATA_W-1:0] a_metric(input logic [IN_W-1:0]   sys,
                                                   input logic [DATA_W-1:0] ext);
        return sat_add(sext(sys), ext);
    endfunction

    // Branch metrics indexed by {u,p}: [0]=00, [1]=01, [2]=10, [3]=11.
    function automatic metric4_t branch_metrics(input logic [IN_W-1:0]   sys,
                                                input logic [IN_W-1:0]   enc,
                                                input logic [DATA_W-1:0] ext);
        metric4_t g;
        logic [DATA_W-1:0] a, e, na, ne;
        a  = a_metric(sys, ext);
        e  = sext(enc);
        na = sat_sub('0, a);
        ne = sat_sub('0, e);
        g[0] = sat_add(na, ne);
        g[1] = sat_add(na, e);
        g[2] = sat_add(a, ne);
        g[3] = sat_add(a, e);
        return g;
    endfunction

    function automatic logic [DATA_W-1:0] path(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] g,
                                               input logic [DATA_W-1:0] b);
        return sat_add(sat_add(a, g), b);
    endfunction

    logic [1:0]        state;
    logic [IDX_W-1:0]  in_idx, bwd_k, out_idx;
    logic              mode_q;
    metric4_t          alpha_mem [K];
    metric4_t          beta_q;
    logic [IN_W-1:0]   sys_mem [K];
    logic [IN_W-1:0]   enc_mem [K];
    logic [DATA_W-1:0] ext_mem [K];
    logic [DATA_W-1:0] llr_buf [K];
    logic              out_valid_q, out_last_q, done_q;
    logic [DATA_W-1:0] llr_q;
    logic              accept;

    metric4_t          g_fwd, alpha_cur, alpha_raw, alpha_next;
    metric4_t          g_bwd, alpha_k, beta_raw, beta_next;
    logic [DATA_W-1:0] m1, m0, llr_full, llr_sel;

    assign in_ready_o  = (state == ST_LOAD);
    assign accept      = in_ready_o & in_valid_i;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign llr_o       = llr_q;
    assign done_o      = done_q;

    // Forward step on the symbol currently at the input port.
    always_comb begin
        g_fwd     = branch_metrics(sys_i, enc_i, ext_i);
        alpha_cur = alpha_mem[in_idx];
        alpha_raw[0] = max2(sat_add(alpha_cur[0], g_fwd[0]), sat_add(alpha_cur[1], g_fwd[2]));
        alpha_raw[1] = max2(sat_add(alpha_cur[2], g_fwd[0]), sat_add(alpha_cur[3], g_fwd[2]));
        alpha_raw[2] = max2(sat_add(alpha_cur[0], g_fwd[3]), sat_add(alpha_cur[1], g_fwd[1]));
        alpha_raw[3] = max2(sat_add(alpha_cur[2], g_fwd[3]), sat_add(alpha_cur[3], g_fwd[1]));
        for (int t = 0; t < 4; t++) begin
            alpha_next[t] = (NORM_EN != 0) ? sat_sub(alpha_raw[t], alpha_raw[0]) : alpha_raw[t];
        end
    end

    // Backward step and LLR for trellis step bwd_k from the stored symbols.
    always_comb begin
        g_bwd   = branch_metrics(sys_mem[bwd_k], enc_mem[bwd_k], ext_mem[bwd_k]);
        alpha_k = alpha_mem[bwd_k];
        beta_raw[0] = max2(sat_add(g_bwd[0], beta_q[0]), sat_add(g_bwd[3], beta_q[2]));
        beta_raw[1] = max2(sat_add(g_bwd[2], beta_q[0]), sat_add(g_bwd[1], beta_q[2]));
        beta_raw[2] = max2(sat_add(g_bwd[0], beta_q[1]), sat_add(g_bwd[3], beta_q[3]));
        beta_raw[3] = max2(sat_add(g_bwd[2], beta_q[1]), sat_add(g_bwd[1], beta_q[3]));
        for (int t = 0; t < 4; t++) begin
            beta_next[t] = (NORM_EN != 0) ? sat_sub(beta_raw[t], beta_raw[0]) : beta_raw[t];
        end
        m1 = max2(max2(path(alpha_k[0], g_bwd[3], beta_q[2]), path(alpha_k[1], g_bwd[2], beta_q[0])),
                  max2(path(alpha_k[2], g_bwd[3], beta_q[3]), path(alpha_k[3], g_bwd[2], beta_q[1])));
        m0 = max2(max2(path(alpha_k[0], g_bwd[0], beta_q[0]), path(alpha_k[1], g_bwd[1], beta_q[2])),
                  max2(path(alpha_k[2], g_bwd[0], beta_q[1]), path(alpha_k[3], g_bwd[1], beta_q[3])));
        llr_full = sat_sub(m1, m0);
        llr_sel  = mode_q ? sat_sub(llr_full, a_metric(sys_mem[bwd_k], ext_mem[bwd_k])) : llr_full;
    end

    // Alpha history; alpha[0] is the fixed start state and is never rewritten.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < K; i++) alpha_mem[i] <= INIT_METRIC;
        end else if (accept && (in_idx != LAST_IDX)) begin
            alpha_mem[in_idx + 1'b1] <= alpha_next;
        end
    end

    // Symbol store during LOAD and LLR buffer writes during BWD.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            sys_mem[in_idx] <= sys_i;
            enc_mem[in_idx] <= enc_i;
            ext_mem[in_idx] <= ext_i;
        end
        if (state == ST_BWD) begin
            llr_buf[bwd_k] <= llr_sel;
        end
    end

    // Block sequencing: LOAD -> BWD -> OUT; OUT spends one cycle priming llr_o.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= ST_LOAD;
            in_idx      <= '0;
            bwd_k       <= '0;
            out_idx     <= '0;
            mode_q      <= 1'b0;
            beta_q      <= INIT_METRIC;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            llr_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        if (in_idx == '0) mode_q <= mode_i;
                        if (in_idx == LAST_IDX) begin
                            state  <= ST_BWD;
                            in_idx <= '0;
                            bwd_k  <= LAST_IDX;
                            beta_q <= INIT_METRIC;
                        end else begin
                            in_idx <= in_idx + 1'b1;
                        end
                    end
                end
                ST_BWD: begin
                    beta_q <= beta_next;
                    if (bwd_k == '0) begin
                        state   <= ST_OUT;
                        out_idx <= '0;
                    end else begin
                        bwd_k <= bwd_k - 1'b1;
                    end
                end
                ST_OUT: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        llr_q       <= llr_buf[0];
                        out_last_q  <= (LAST_IDX == '0);
                    end else if (out_ready_i) begin
                        if (out_idx == LAST_IDX) begin
                            state       <= ST_LOAD;
                            out_idx     <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            llr_q       <= '0;
                            done_q      <= 1'b1;
                        end else begin
                            out_idx    <= out_idx + 1'b1;
                            llr_q      <= llr_buf[out_idx + 1'b1];
                            out_last_q <= ((out_idx + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_siso_maxlog_stream.sv
// Testbench for siso_maxlog_stream: a 10-bit and a 6-bit instance run in
// lockstep on the same stimulus, each checked against a saturating model.
module tb_siso_maxlog_stream;

    localparam int K       = 7;
    localparam int NORM_EN = 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       mode = 1'b0;
    logic [3:0] sys = '0;
    logic [3:0] enc = '0;
    logic [9:0] ext = '0;
    logic [5:0] ext6 = '0;

    logic       in_ready, out_valid, out_last, done;
    logic [9:0] llr;
    logic       in_ready6, out_valid6, out_last6, done6;
    logic [5:0] llr6;

    siso_maxlog_stream #(.DATA_W(10), .IN_W(4), .K(K), .NORM_EN(NORM_EN)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .sys_i(sys), .enc_i(enc), .ext_i(ext), .mode_i(mode),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .llr_o(llr),
        .out_last_o(out_last), .done_o(done)
    );

    siso_maxlog_stream #(.DATA_W(6), .IN_W(4), .K(K), .NORM_EN(NORM_EN)) dut6 (
        .clk_i(clk), .reset_n_i(reset_n), .in_valid_i(in_valid), .in_ready_o(in_ready6),
        .sys_i(sys), .enc_i(enc), .ext_i(ext6), .mode_i(mode),
        .out_valid_o(out_valid6), .out_ready_i(out_ready), .llr_o(llr6),
        .out_last_o(out_last6), .done_o(done6)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        bit mode;
        bit gaps;
        int stallK;
        bit patterned;
        int seed;
        int sysC;
        int encC;
        int extC;
        int expKind;
    } vec_t;

    vec_t vecs [7];

    int nTests = 0;
    int nFail  = 0;
    int acceptCyc = 0;
    int q10 [$];
    int q6  [$];
    int mSys [K];
    int mEnc [K];
    int mExt [K];
    int mLlr [K];
    int fullRef [K];
    int cap [7][K];

    int brFrom [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int brTo   [8] = '{0, 2, 0, 2, 1, 3, 1, 3};
    int brU    [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    int brP    [8] = '{0, 1, 0, 1, 0, 1, 0, 1};

    task automatic checkVal(input string name, input int act, input int exp);
        nTests++;
        if (act != exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int satw(input int x, input int w);
        int lo, hi;
        lo = -(1 << (w - 1));
        hi = (1 << (w - 1)) - 1;
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    // Saturating max-log-MAP reference over the branch table, width w.
    task automatic runModel(input int w, input bit md);
        int al [K+1][4];
        int be [4];
        int nv [4];
        int gam [K][4];
        int aa [K];
        int ua, pe, v, v2, m1, m0, neg, gi, ex;
        neg = -(1 << (w - 1));
        for (int k = 0; k < K; k++) begin
            ex = satw(mExt[k], w);
            aa[k] = satw(mSys[k] + ex, w);
            for (int u = 0; u < 2; u++) begin
                for (int p = 0; p < 2; p++) begin
                    ua = (u == 1) ? aa[k] : satw(-aa[k], w);
                    pe = (p == 1) ? mEnc[k] : satw(-mEnc[k], w);
                    gam[k][u*2+p] = satw(ua + pe, w);
                end
            end
        end
        al[0] = '{0, neg, neg, neg};
        for (int k = 0; k < K; k++) begin
            nv = '{-1000000, -1000000, -1000000, -1000000};
            for (int b = 0; b < 8; b++) begin
                gi = brU[b] * 2 + brP[b];
                v = satw(al[k][brFrom[b]] + gam[k][gi], w);
                if (v > nv[brTo[b]]) nv[brTo[b]] = v;
            end
            for (int t = 0; t < 4; t++) al[k+1][t] = (NORM_EN != 0) ? satw(nv[t] - nv[0], w) : nv[t];
        end
        be = '{0, neg, neg, neg};
        for (int k = K - 1; k >= 0; k--) begin
            m1 = -1000000;
            m0 = -1000000;
            nv = '{-1000000, -1000000, -1000000, -1000000};
            for (int b = 0; b < 8; b++) begin
                gi = brU[b] * 2 + brP[b];
                v = satw(satw(al[k][brFrom[b]] + gam[k][gi], w) + be[brTo[b]], w);
                if (brU[b] == 1) begin
                    if (v > m1) m1 = v;
                end else begin
                    if (v > m0) m0 = v;
                end
                v2 = satw(gam[k][gi] + be[brTo[b]], w);
                if (v2 > nv[brFrom[b]]) nv[brFrom[b]] = v2;
            end
            mLlr[k] = satw(m1 - m0, w);
            if (md) mLlr[k] = satw(mLlr[k] - aa[k], w);
            for (int t = 0; t < 4; t++) be[t] = (NORM_EN != 0) ? satw(nv[t] - nv[0], w) : nv[t];
        end
    endtask

    // Expands a table entry, pushes model results and feeds the K symbols.
    task automatic applyStimulus(input int v);
        vec_t t;
        int n, cnt;
        t = vecs[v];
        for (int k = 0; k < K; k++) begin
            if (t.patterned) begin
                mSys[k] = ((t.seed + 3 * k) % 16) - 8;
                mEnc[k] = ((t.seed * 5 + 7 * k) % 16) - 8;
                mExt[k] = ((t.seed * 11 + 13 * k) % 61) - 30;
            end else begin
                mSys[k] = t.sysC;
                mEnc[k] = t.encC;
                mExt[k] = t.extC;
            end
        end
        runModel(10, t.mode);
        if (v == 1) fullRef = mLlr;
        for (int k = 0; k < K; k++) q10.push_back(mLlr[k]);
        runModel(6, t.mode);
        for (int k = 0; k < K; k++) q6.push_back(mLlr[k]);
        for (int k = 0; k < K; k++) begin
            n = t.gaps ? int'($urandom_range(0, 2)) : 0;
            repeat (n) begin
                in_valid = 1'b0;
                sys = 4'($urandom);
                enc = 4'($urandom);
                ext = 10'($urandom);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            sys  = 4'(mSys[k]);
            enc  = 4'(mEnc[k]);
            ext  = 10'(mExt[k]);
            ext6 = 6'(satw(mExt[k], 6));
            mode = (k == 0) ? t.mode : !t.mode;
            cnt = 0;
            @(negedge clk);
            while (!in_ready && cnt < 50) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= 50) checkVal($sformatf("vec%0d in_ready timeout", v), 0, 1);
            @(posedge clk);
            #1;
            acceptCyc = cyc;
        end
        in_valid = 1'b0;
    endtask

    // Drains one block, comparing each handshake against the scoreboard.
    task automatic checkOutput(input int v, input int stallK);
        int idx, budget, stallLeft, expv;
        bit seen;
        idx = 0;
        budget = 0;
        stallLeft = 3;
        seen = 1'b0;
        while (idx < K && budget < 200) begin
            @(posedge clk);
            #1;
            out_ready = (idx == stallK && stallLeft > 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            budget++;
            if (out_valid && !seen) begin
                seen = 1'b1;
                checkVal($sformatf("vec%0d latency", v), cyc - acceptCyc, K + 1);
            end
            if (out_valid) begin
                if (q10.size() == 0 || q6.size() == 0) begin
                    checkVal($sformatf("vec%0d scoreboard underflow", v), 1, 0);
                    idx = K;
                end else if (!out_ready) begin
                    checkVal($sformatf("vec%0d k%0d held llr", v, idx), int'($signed(llr)), q10[0]);
                    stallLeft--;
                end else begin
                    expv = q10.pop_front();
                    checkVal($sformatf("vec%0d k%0d llr", v, idx), int'($signed(llr)), expv);
                    expv = q6.pop_front();
                    checkVal($sformatf("vec%0d k%0d llr6", v, idx), int'($signed(llr6)), expv);
                    checkVal($sformatf("vec%0d k%0d valid6", v, idx), int'(out_valid6), 1);
                    checkVal($sformatf("vec%0d k%0d last", v, idx), int'(out_last), int'(idx == K - 1));
                    checkVal($sformatf("vec%0d k%0d last6", v, idx), int'(out_last6), int'(idx == K - 1));
                    cap[v][idx] = int'($signed(llr));
                    idx++;
                end
            end
        end
        if (idx < K) checkVal($sformatf("vec%0d output timeout", v), idx, K);
        out_ready = 1'b1;
        @(negedge clk);
        checkVal($sformatf("vec%0d done pulse", v), int'(done), 1);
        checkVal($sformatf("vec%0d done6 pulse", v), int'(done6), 1);
        checkVal($sformatf("vec%0d valid after last", v), int'(out_valid), 0);
        @(negedge clk);
        checkVal($sformatf("vec%0d done single", v), int'(done), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, " in_ready"}, int'(in_ready), 1);
        checkVal({tag, " in_ready6"}, int'(in_ready6), 1);
        checkVal({tag, " out_valid"}, int'(out_valid), 0);
        checkVal({tag, " out_last"}, int'(out_last), 0);
        checkVal({tag, " done"}, int'(done), 0);
        checkVal({tag, " llr"}, int'(llr), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //          mode  gaps stallK patt seed sys enc ext expKind
        vecs[0] = '{1'b0, 1'b0, -1, 1'b0, 0,  0,  0,  0, 1};
        vecs[1] = '{1'b0, 1'b0, -1, 1'b0, 0, -3, -3,  0, 2};
        vecs[2] = '{1'b1, 1'b0, -1, 1'b0, 0, -3, -3,  0, 0};
        vecs[3] = '{1'b0, 1'b0, -1, 1'b0, 0,  7,  7, 31, 0};
        vecs[4] = '{1'b0, 1'b1,  2, 1'b1, 5,  0,  0,  0, 0};
        vecs[5] = '{1'b0, 1'b0, -1, 1'b1, 5,  0,  0,  0, 0};
        vecs[6] = '{1'b1, 1'b1, -1, 1'b1, 9,  0,  0,  0, 0};

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("por");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            applyStimulus(v);
            checkOutput(v, vecs[v].stallK);
            for (int k = 0; k < K; k++) begin
                if (vecs[v].expKind == 1) checkVal($sformatf("zeros k%0d", k), cap[v][k], 0);
                if (vecs[v].expKind == 2) checkVal($sformatf("clean negative k%0d", k), int'(cap[v][k] < 0), 1);
            end
        end
        for (int k = 0; k < K; k++) begin
            checkVal($sformatf("extrinsic k%0d", k), cap[2][k], fullRef[k] + 3);
        end

        applyStimulus(1);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkReset("abort");
        @(negedge clk);
        reset_n = 1'b1;
        q10.delete();
        q6.delete();
        @(posedge clk);
        #1;
        applyStimulus(3);
        checkOutput(3, -1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
